// File: rtl/aib_rx_lane_align.sv
// DDR Rx lane deskew: per-lane programmable delay lines trained by a marker-search FSM.
// Define AIB_RX_ALIGN_ERRCNT_EN to add o_err_cnt, a saturating count of failed training attempts.

module aib_rx_lane_dly #(
    parameter int MaxSkew = 3,
    parameter int DW      = $clog2(MaxSkew + 1)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_d0,
    input  logic          i_d1,
    input  logic          i_del_clr,
    input  logic          i_del_ld,
    input  logic [DW-1:0] i_del_val,
    output logic          o_d0,
    output logic          o_d1
);
    logic [MaxSkew:0] r_sh0;
    logic [MaxSkew:0] r_sh1;
    logic [DW-1:0]    r_del;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sh0 <= '0;
            r_sh1 <= '0;
            r_del <= '0;
        end else begin
            r_sh0 <= {r_sh0[MaxSkew-1:0], i_d0};
            r_sh1 <= {r_sh1[MaxSkew-1:0], i_d1};
            if (i_del_clr)
                r_del <= '0;
            else if (i_del_ld)
                r_del <= i_del_val;
        end
    end

    // Tap k holds the input from k+1 cycles ago.
    assign o_d0 = r_sh0[r_del];
    assign o_d1 = r_sh1[r_del];
endmodule

module aib_rx_lane_align #(
    parameter int NumLanes     = 20,
    parameter int MaxSkew      = 3,
    parameter int MarkerPeriod = 16,
    parameter int MaxRetry     = 3
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_train_start,
    input  logic [NumLanes-1:0] i_rx_data0,
    input  logic [NumLanes-1:0] i_rx_data1,
    output logic [NumLanes-1:0] o_rx_data0,
    output logic [NumLanes-1:0] o_rx_data1,
    output logic                o_locked,
    output logic                o_fail,
`ifdef AIB_RX_ALIGN_ERRCNT_EN
    output logic [7:0]          o_err_cnt,
`endif
    output logic [1:0]          o_state
);
    localparam int DW  = $clog2(MaxSkew + 1);
    localparam int TMO = 2 * MarkerPeriod;
    localparam int TW  = $clog2(TMO);
    localparam int RW  = $clog2(MaxRetry + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        VERIFY = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_nstate;
    logic                        r_open;
    logic [DW-1:0]               r_win;
    logic [NumLanes-1:0]         r_got;
    logic [NumLanes-1:0][DW-1:0] r_arr;
    logic [TW-1:0]               r_tmo;
    logic [RW-1:0]               r_retry;
    logic                        r_locked;
    logic                        r_fail;

    logic [NumLanes-1:0]         w_mk;
    logic [NumLanes-1:0]         w_omk;
    logic                        w_open_now;
    logic [DW-1:0]               w_win;
    logic [NumLanes-1:0]         w_got;
    logic [NumLanes-1:0][DW-1:0] w_arr;
    logic [DW-1:0]               w_max;
    logic [NumLanes-1:0][DW-1:0] w_del_val;
    logic                        w_close;
    logic                        w_del_clr;
    logic                        w_del_ld;
    logic                        w_fail_evt;
    logic                        w_lock_evt;

    assign w_mk  = i_rx_data0 & i_rx_data1;
    assign w_omk = o_rx_data0 & o_rx_data1;

    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        aib_rx_lane_dly #(.MaxSkew(MaxSkew), .DW(DW)) u_lane (
            .i_clk     (i_clk),
            .i_rstn    (i_rstn),
            .i_d0      (i_rx_data0[l]),
            .i_d1      (i_rx_data1[l]),
            .i_del_clr (w_del_clr),
            .i_del_ld  (w_del_ld),
            .i_del_val (w_del_val[l]),
            .o_d0      (o_rx_data0[l]),
            .o_d1      (o_rx_data1[l])
        );
    end

    // Arrival bookkeeping for the current cycle; a lane keeps its first offset.
    always_comb begin
        w_open_now = r_open | (|w_mk);
        w_win      = r_open ? DW'(r_win + 1'b1) : '0;
        w_max      = '0;
        w_got      = '0;
        w_arr      = '0;
        w_del_val  = '0;
        for (int l = 0; l < NumLanes; l++) begin
            w_got[l] = r_got[l] | w_mk[l];
            w_arr[l] = r_got[l] ? r_arr[l] : w_win;
        end
        for (int l = 0; l < NumLanes; l++) begin
            if (w_got[l] && (w_arr[l] > w_max))
                w_max = w_arr[l];
        end
        for (int l = 0; l < NumLanes; l++)
            w_del_val[l] = w_max - w_arr[l];
    end

    always_comb begin
        w_nstate   = r_state;
        w_close    = 1'b0;
        w_del_clr  = 1'b0;
        w_del_ld   = 1'b0;
        w_fail_evt = 1'b0;
        w_lock_evt = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_open_now && (w_win == DW'(MaxSkew))) begin
                    w_close = 1'b1;
                    if (&w_got) begin
                        w_del_ld = 1'b1;
                        w_nstate = VERIFY;
                    end else begin
                        w_fail_evt = 1'b1;
                    end
                end else if (!w_open_now && (r_tmo == TW'(TMO - 1))) begin
                    w_fail_evt = 1'b1;
                end
            end
            VERIFY: begin
                if (|w_omk) begin
                    if (&w_omk) begin
                        w_lock_evt = 1'b1;
                        w_nstate   = LOCKED;
                    end else begin
                        w_fail_evt = 1'b1;
                    end
                end else if (r_tmo == TW'(TMO - 1)) begin
                    w_fail_evt = 1'b1;
                end
            end
            default: ;
        endcase
        if (w_fail_evt) begin
            if (int'(r_retry) + 1 < MaxRetry) begin
                w_del_clr = 1'b1;
                w_nstate  = SEARCH;
            end else begin
                w_nstate = IDLE;
            end
        end
        // A restart overrides whatever the current attempt decided.
        if (i_train_start) begin
            w_nstate   = SEARCH;
            w_del_clr  = 1'b1;
            w_del_ld   = 1'b0;
            w_fail_evt = 1'b0;
            w_lock_evt = 1'b0;
            w_close    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= IDLE;
            r_open   <= 1'b0;
            r_win    <= '0;
            r_got    <= '0;
            r_arr    <= '0;
            r_tmo    <= '0;
            r_retry  <= '0;
            r_locked <= 1'b0;
            r_fail   <= 1'b0;
        end else begin
            r_state <= w_nstate;

            if ((r_state == SEARCH) && (w_nstate == SEARCH) && !w_close &&
                !w_fail_evt && !i_train_start) begin
                r_open <= w_open_now;
                r_win  <= w_win;
                r_got  <= w_open_now ? w_got : '0;
                r_arr  <= w_arr;
            end else begin
                r_open <= 1'b0;
                r_win  <= '0;
                r_got  <= '0;
                r_arr  <= '0;
            end

            // Idle-cycle counter: marker-free SEARCH cycles, or any VERIFY cycle.
            if ((w_nstate != r_state) || w_fail_evt || i_train_start)
                r_tmo <= '0;
            else if (((r_state == SEARCH) && !w_open_now) || (r_state == VERIFY))
                r_tmo <= r_tmo + 1'b1;
            else
                r_tmo <= '0;

            if (i_train_start)
                r_retry <= '0;
            else if (w_fail_evt)
                r_retry <= r_retry + 1'b1;

            if (i_train_start)
                r_locked <= 1'b0;
            else if (w_lock_evt)
                r_locked <= 1'b1;

            if (i_train_start)
                r_fail <= 1'b0;
            else if (w_fail_evt && (w_nstate == IDLE))
                r_fail <= 1'b1;
        end
    end

`ifdef AIB_RX_ALIGN_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            r_err_cnt <= '0;
        else if (w_fail_evt && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign o_err_cnt = r_err_cnt;
`endif

    assign o_locked = r_locked;
    assign o_fail   = r_fail;
    assign o_state  = r_state;
endmodule
